signed_seq_divider: RTL and testbench
=====================================

// Module: signed_seq_divider
// PURPOSE
//  Sequential signed divider; the inverse of the 4-bit signed Booth multiplier datapath.
//  Takes a 2N-bit signed dividend (e.g. a multiplier product) and an N-bit signed divisor.
//  Returns the quotient and remainder after a fixed iteration count, one bit per clock.
//  Sits beside the multiplier in the arithmetic top level and shares its start/done handshake style.
// PARAMETERS
//  N    4    divisor/remainder width; dividend and quotient are 2N bits
// PORTS
//  i_clk          in   1    single clock, all state on rising edge
//  i_rst_n        in   1    reset, asynchronous, active-low
//  start          in   1    request; sampled only in IDLE
//  op_dividend    in   2N   signed dividend (two's complement)
//  op_divisor     in   N    signed divisor (two's complement)
//  o_quotient     out  2N   signed quotient, truncated toward zero
//  o_remainder    out  N    signed remainder, sign follows dividend
//  o_assert_done  out  1    one-cycle pulse; results valid from this cycle
//  o_busy         out  1    high in CALC and FIX
//  o_div_zero     out  1    divisor was 0 for the last operation
//  o_ovf          out  1    quotient overflowed 2N bits (-2^(2N-1) / -1)
// BEHAVIOUR
//  Reset: async clear of all registers; state=IDLE.
//   All outputs are 0 until the first completed operation.
//  States: IDLE, CALC, FIX.
//  IDLE with start=1 at edge k:
//   - Latch |dividend| into Q (2N bits), |divisor| into D (N bits, unsigned).
//   - Clear A (N+1 bits) and count; latch both operand signs.
//   - Operands are ignored after edge k.
//   - Go to CALC. If divisor==0, go to FIX with a div-zero flag instead.
//  CALC, one restoring step per edge, 2N steps:
//   - {A,Q} <<= 1; T = A - D (N+1 bits).
//   - If T >= 0: A = T, Q[0] = 1. Else Q[0] = 0.
//   - count increments; after step 2N (edge k+2N) go to FIX.
//  FIX, edge k+2N+1 (latency 2N+1 cycles; 9 for N=4):
//   - o_quotient = neg(Q) if the signs differ, else Q.
//   - o_remainder = neg(A[N-1:0]) if the dividend is negative, else A[N-1:0].
//   - o_ovf = 1 iff dividend = -2^(2N-1) and divisor = -1.
//     The quotient wraps to -2^(2N-1).
//   - o_div_zero = 0.
//   - o_assert_done = 1 for one cycle; go to IDLE.
//  Divide by zero: FIX is reached at edge k+1 (done at k+1).
//   - o_quotient = 0, o_remainder = 0, o_div_zero = 1, o_ovf = 0.
//  Results and flags hold until the next FIX. o_assert_done is 0 in all other cycles.
//  start while busy: ignored, with no queueing.
//   start high in the same cycle as done: not accepted, because the state is FIX.
//   It is accepted on the following edge if still high.
//  Widths: |divisor| up to 2^(N-1) needs N bits unsigned. A needs N+1 bits for the compare.
//   |remainder| < |divisor|, so it always fits N bits signed.
//  Reset mid-operation: abort immediately; outputs return to 0; no done pulse.
// TESTING
//  1 -56/-7 (8'hC8, 4'h9), start at edge k -> done at k+9, Q=8, R=0, ovf=0, dz=0.
//  2 100/7 -> Q=14, R=2; -100/7 -> Q=-14 (8'hF2), R=-2 (4'hE); 7/-8 -> Q=0, R=7.
//  3 5/0 -> done at k+1, dz=1, Q=0, R=0; a following 6/3 -> dz=0, Q=2, R=0.
//  4 -128/-1 -> Q=8'h80, R=0, ovf=1; then 127/-1 -> Q=-127, ovf=0.
//  5 start held high for 20 cycles with changing operands -> exactly two operations.
//    Each uses the operands at its acceptance edge; done pulses are 10 cycles apart.
//  6 i_rst_n low at step 4 of CALC -> all outputs 0, no done; a new start then completes normally.

Source files
------------

// File: rtl/signed_seq_divider.sv
// signed_seq_divider: sequential signed divider, restoring algorithm, one
// quotient bit per clock. Divides a 2N-bit signed dividend by an N-bit signed
// divisor. The quotient truncates toward zero and the remainder takes the
// sign of the dividend. Results and flags hold until the next operation ends.
module signed_seq_divider #(
    parameter int N = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   op_dividend,
    input  logic [N-1:0]     op_divisor,
    output logic [2*N-1:0]   o_quotient,
    output logic [N-1:0]     o_remainder,
    output logic             o_assert_done,
    output logic             o_busy,
    output logic             o_div_zero,
    output logic             o_ovf
);

    localparam int              CW        = $clog2(2*N) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(2*N - 1);
    localparam logic [2*N-1:0]  DVD_MIN   = {1'b1, {(2*N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    // Partial remainder. Between steps it is always below |divisor| <= 2^(N-1),
    // so N bits hold it; the extra compare bit exists only in a_sh below.
    logic [N-1:0]    a_q,          a_d;
    logic [2*N-1:0]  q_q,          q_d;
    logic [N-1:0]    d_q,          d_d;
    logic [CW-1:0]   cnt_q,        cnt_d;
    logic            dvd_neg_q,    dvd_neg_d;
    logic            dvs_neg_q,    dvs_neg_d;
    logic            dz_pend_q,    dz_pend_d;
    logic            ovf_pend_q,   ovf_pend_d;
    logic [2*N-1:0]  quot_q,       quot_d;
    logic [N-1:0]    rem_q,        rem_d;
    logic            done_q,       done_d;
    logic            dz_q,         dz_d;
    logic            ovf_q,        ovf_d;

    // Magnitudes of the operands. The most negative value maps to its
    // unsigned magnitude (e.g. 8'h80 -> 128), which still fits the width.
    logic [2*N-1:0]  dvd_abs;
    logic [N-1:0]    dvs_abs;
    assign dvd_abs = op_dividend[2*N-1] ? -op_dividend : op_dividend;
    assign dvs_abs = op_divisor[N-1]    ? -op_divisor  : op_divisor;

    // One restoring step: shift {A,Q} left by one, then trial-subtract D.
    logic [N:0]      a_sh;
    logic            step_ge;
    logic [N-1:0]    step_diff;
    assign a_sh      = {a_q, q_q[2*N-1]};
    assign step_ge   = (a_sh >= {1'b0, d_q});
    // When the subtraction succeeds the result is below D, so its low N bits
    // are exact even though a_sh itself needs N+1 bits.
    assign step_diff = a_sh[N-1:0] - d_q;

    // Next-state and datapath update for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        dz_pend_d  = dz_pend_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d        = dvd_abs;
                    d_d        = dvs_abs;
                    a_d        = '0;
                    cnt_d      = '0;
                    dvd_neg_d  = op_dividend[2*N-1];
                    dvs_neg_d  = op_divisor[N-1];
                    dz_pend_d  = (op_divisor == '0);
                    ovf_pend_d = (op_dividend == DVD_MIN) && (op_divisor == '1);
                    // A zero divisor skips the iteration and finishes next edge.
                    state_d    = (op_divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (step_ge) begin
                    a_d = step_diff;
                    q_d = {q_q[2*N-2:0], 1'b1};
                end else begin
                    a_d = a_sh[N-1:0];
                    q_d = {q_q[2*N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_pend_q) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    // -128/-1 gives magnitude 128 with equal signs, which
                    // naturally wraps to 8'h80; ovf_pend_q flags that case.
                    quot_d = (dvd_neg_q ^ dvs_neg_q) ? -q_q : q_q;
                    rem_d  = dvd_neg_q ? -a_q : a_q;
                    dz_d   = 1'b0;
                    ovf_d  = ovf_pend_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            dz_pend_q  <= dz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_quotient    = quot_q;
    assign o_remainder   = rem_q;
    assign o_assert_done = done_q;
    assign o_busy        = (state_q == CALC) || (state_q == FIX);
    assign o_div_zero    = dz_q;
    assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: random and directed stimulus for signed_seq_divider,
// checked every cycle against a timing/arithmetic model of the divider.
module tb_signed_seq_divider;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [2*N-1:0]  op_dividend = '0;
    logic [N-1:0]    op_divisor = '0;
    logic [2*N-1:0]  o_quotient;
    logic [N-1:0]    o_remainder;
    logic            o_assert_done;
    logic            o_busy;
    logic            o_div_zero;
    logic            o_ovf;

    int n_vec = 0;
    int n_err = 0;

    signed_seq_divider #(.N(N)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .start         (start),
        .op_dividend   (op_dividend),
        .op_divisor    (op_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_assert_done (o_assert_done),
        .o_busy        (o_busy),
        .o_div_zero    (o_div_zero),
        .o_ovf         (o_ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: plain integer division (truncates toward zero,
    // remainder follows the dividend), results wrapped to the output widths.
    task automatic model_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                            output logic [2*N-1:0] q, output logic [N-1:0] r,
                            output bit dz, output bit ovf);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = '0; r = '0; dz = 1'b1; ovf = 1'b0;
        end else begin
            qi  = ai / bi;
            ri  = ai % bi;
            q   = qi[2*N-1:0];
            r   = ri[N-1:0];
            dz  = 1'b0;
            ovf = (qi > (2**(2*N-1) - 1));
        end
    endtask

    // Model: an accepted operation finishes a fixed number of edges later;
    // the done edge itself cannot accept a new request.
    int              cyc = 0;
    int              done_cyc = 0;
    bit              in_flight = 1'b0;
    logic [2*N-1:0]  pend_q = '0;
    logic [N-1:0]    pend_r = '0;
    bit              pend_dz = 1'b0;
    bit              pend_ovf = 1'b0;
    logic [2*N-1:0]  exp_q = '0;
    logic [N-1:0]    exp_r = '0;
    bit              exp_done = 1'b0;
    bit              exp_busy = 1'b0;
    bit              exp_dz = 1'b0;
    bit              exp_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight = 1'b0;
            exp_q = '0; exp_r = '0; exp_done = 1'b0;
            exp_busy = 1'b0; exp_dz = 1'b0; exp_ovf = 1'b0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (in_flight && cyc == done_cyc) begin
                exp_q = pend_q; exp_r = pend_r;
                exp_dz = pend_dz; exp_ovf = pend_ovf;
                exp_done = 1'b1;
                in_flight = 1'b0;
            end else if (!in_flight && start) begin
                model_op(op_dividend, op_divisor, pend_q, pend_r, pend_dz, pend_ovf);
                done_cyc = cyc + (pend_dz ? 1 : 2*N + 1);
                in_flight = 1'b1;
            end
            exp_busy = in_flight;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        n_vec++;
        if ({o_quotient, o_remainder, o_assert_done, o_busy, o_div_zero, o_ovf} !==
            {exp_q, exp_r, exp_done, exp_busy, exp_dz, exp_ovf}) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL cycle_check t=%0t got q=%h r=%h done=%b busy=%b dz=%b ovf=%b want q=%h r=%h done=%b busy=%b dz=%b ovf=%b",
                         $time, o_quotient, o_remainder, o_assert_done, o_busy, o_div_zero, o_ovf,
                         exp_q, exp_r, exp_done, exp_busy, exp_dz, exp_ovf);
        end
    end

    function automatic logic [2*N-1:0] pick_dvd();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [N-1:0] pick_dvs();
        case ($urandom_range(0, 7))
            0:       return 4'h0;
            1:       return 4'hF;
            2:       return 4'h8;
            3:       return 4'h7;
            4:       return 4'h1;
            default: return 4'($urandom);
        endcase
    endfunction

    // Directed operation with literal expected results and latency.
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] eq, input logic [N-1:0] er,
                          input bit edz, input bit eovf, input int elat, input string name);
        int lat;
        @(negedge clk);
        op_dividend = a; op_divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_dividend = 8'($urandom); op_divisor = 4'($urandom);
        lat = 0;
        while (!o_assert_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (!o_assert_done || lat != elat || o_quotient !== eq || o_remainder !== er ||
            o_div_zero !== edz || o_ovf !== eovf) begin
            n_err++;
            $display("FAIL %s got lat=%0d q=%h r=%h dz=%b ovf=%b want lat=%0d q=%h r=%h dz=%b ovf=%b",
                     name, lat, o_quotient, o_remainder, o_div_zero, o_ovf, elat, eq, er, edz, eovf);
        end else begin
            $display("op %s: %h / %h -> q=%h r=%h dz=%b ovf=%b lat=%0d", name, a, b,
                     o_quotient, o_remainder, o_div_zero, o_ovf, lat);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({o_quotient, o_remainder, o_assert_done, o_busy, o_div_zero, o_ovf} !== '0) begin
            n_err++;
            $display("FAIL %s got q=%h r=%h done=%b busy=%b dz=%b ovf=%b want all 0",
                     name, o_quotient, o_remainder, o_assert_done, o_busy, o_div_zero, o_ovf);
        end
    endtask

    initial begin
        int dones, t1, t2;
        logic [N-1:0] dv;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        #2 rst_n = 1'b1;

        run_op(8'hC8, 4'h9, 8'h08, 4'h0, 1'b0, 1'b0, 9, "m56_by_m7");
        run_op(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b0, 9, "100_by_7");
        run_op(8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0, 9, "m100_by_7");
        run_op(8'd7, 4'h8, 8'h00, 4'h7, 1'b0, 1'b0, 9, "7_by_m8");
        run_op(8'd5, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1, "5_by_0");
        run_op(8'd6, 4'd3, 8'h02, 4'h0, 1'b0, 1'b0, 9, "6_by_3");
        run_op(8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 9, "m128_by_m1");
        run_op(8'h7F, 4'hF, 8'h81, 4'h0, 1'b0, 1'b0, 9, "127_by_m1");

        // start held for 20 edges with operands changing every cycle
        dones = 0; t1 = -1; t2 = -1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            if (i < 20) begin
                dv = pick_dvs();
                if (dv == '0) dv = 4'h3;
                start = 1'b1; op_dividend = pick_dvd(); op_divisor = dv;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (o_assert_done) begin
                dones++;
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        n_vec++;
        if (dones != 2 || (t2 - t1) != 10) begin
            n_err++;
            $display("FAIL held_start got dones=%0d spacing=%0d want dones=2 spacing=10", dones, t2 - t1);
        end else begin
            $display("op held_start: dones=%0d spacing=%0d", dones, t2 - t1);
        end

        // reset in the middle of CALC
        @(negedge clk);
        op_dividend = 8'd77; op_divisor = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_calc");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_zero("no_done_after_abort");
        run_op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 1'b0, 9, "77_by_5_after_reset");

        // random traffic, including requests while busy
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op_dividend = pick_dvd();
            op_divisor = pick_dvs();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
